regfile_writeback: RTL and testbench



---
 rtl/riscv_pkg.sv | 18 +
 rtl/wb_fifo.sv | 89 ++++++++
 rtl/regfile_writeback.sv | 127 ++++++++++++
 tb/tb_regfile_writeback.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths and types for the register-file write-back path.
//   XLEN       - register data width
//   REG_ADDR_W - register index width
//   X0         - index of the hard-wired zero register
//   wb_entry_t - write-back entry layout {rd, data}
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] X0 = '0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO buffering memory-channel write-back entries.
//   clk, reset          - clock, synchronous active-high reset (flushes)
//   push/push_rd/_data  - enqueue an entry (caller guarantees !full)
//   pop                 - dequeue head (caller guarantees !empty)
//   head_rd/head_data   - oldest entry
//   count/full/empty    - occupancy
//   ent_vld/ent_rd      - per-slot valid mask and rd, for busy comparators
module wb_fifo #(
  parameter  int DEPTH  = 4,
  parameter  int RD_W   = 5,
  parameter  int DATA_W = 32,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [RD_W-1:0]              push_rd,
  input  logic [DATA_W-1:0]            push_data,
  input  logic                         pop,
  output logic [RD_W-1:0]              head_rd,
  output logic [DATA_W-1:0]            head_data,
  output logic [CNT_W-1:0]             count,
  output logic                         full,
  output logic                         empty,
  output logic [DEPTH-1:0]             ent_vld,
  output logic [DEPTH-1:0][RD_W-1:0]   ent_rd
);

  logic [DEPTH-1:0][RD_W-1:0]   rd_q,   rd_d;
  logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
  logic [DEPTH-1:0]             vld_q,  vld_d;
  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]             cnt_q,  cnt_d;

  // Push and pop never address the same slot: pop needs count>0, push needs
  // count<DEPTH, so when both fire the pointers differ.
  always_comb begin
    rd_d     = rd_q;
    data_d   = data_q;
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      rd_d[wr_ptr_q]   = push_rd;
      data_d[wr_ptr_q] = push_data;
      vld_d[wr_ptr_q]  = 1'b1;
      wr_ptr_d         = wr_ptr_q + 1'b1;  // power-of-2 depth: natural wrap
    end
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q     <= '0;
      data_q   <= '0;
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_q     <= rd_d;
      data_q   <= data_d;
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head_rd   = rd_q[rd_ptr_q];
  assign head_data = data_q[rd_ptr_q];
  assign count     = cnt_q;
  assign full      = (cnt_q == CNT_W'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign ent_vld   = vld_q;
  assign ent_rd    = rd_q;

endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: merges an ALU result channel and a buffered memory
// result channel onto the single register-file write port.
//   clk, reset                 - clock, synchronous active-high reset
//   alu_valid/ready/rd/data    - single-cycle ALU results (priority)
//   mem_valid/ready/rd/data    - load results, buffered in wb_fifo
//   write_reg/data, reg_write  - registered register-file write port
//   query_rs1/2, busy_rs1/2    - pending-write lookup for the hazard unit
//   fifo_count                 - memory buffer occupancy
module regfile_writeback #(
  parameter int XLEN       = riscv_pkg::XLEN,
  parameter int REG_ADDR_W = riscv_pkg::REG_ADDR_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          alu_valid,
  output logic                          alu_ready,
  input  logic [REG_ADDR_W-1:0]         alu_rd,
  input  logic [XLEN-1:0]               alu_data,
  input  logic                          mem_valid,
  output logic                          mem_ready,
  input  logic [REG_ADDR_W-1:0]         mem_rd,
  input  logic [XLEN-1:0]               mem_data,
  output logic [REG_ADDR_W-1:0]         write_reg,
  output logic [XLEN-1:0]               write_data,
  output logic                          reg_write,
  input  logic [REG_ADDR_W-1:0]         query_rs1,
  input  logic [REG_ADDR_W-1:0]         query_rs2,
  output logic                          busy_rs1,
  output logic                          busy_rs2,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  import riscv_pkg::*;

  localparam logic [REG_ADDR_W-1:0] RD_ZERO = REG_ADDR_W'(X0);

  logic                                 full, empty;
  logic                                 alu_fire, alu_wr, mem_fire, push, pop;
  logic [REG_ADDR_W-1:0]                head_rd;
  logic [XLEN-1:0]                      head_data;
  logic [FIFO_DEPTH-1:0]                ent_vld;
  logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0] ent_rd;

  logic [REG_ADDR_W-1:0] write_reg_q,  write_reg_d;
  logic [XLEN-1:0]       write_data_q, write_data_d;
  logic                  reg_write_q,  reg_write_d;

  // Ready only looks at registered occupancy, so there is no valid->ready path.
  assign alu_ready = !full;
  assign mem_ready = !full;

  assign alu_fire = alu_valid && alu_ready;
  assign alu_wr   = alu_fire && (alu_rd != RD_ZERO);
  assign mem_fire = mem_valid && mem_ready;
  assign push     = mem_fire && (mem_rd != RD_ZERO);
  // An rd=0 ALU handshake leaves the port free for the FIFO head. When full,
  // alu_ready is low so the pop is guaranteed and full lasts one cycle.
  assign pop      = !empty && !alu_wr;

  wb_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .RD_W   (REG_ADDR_W),
    .DATA_W (XLEN)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_rd   (mem_rd),
    .push_data (mem_data),
    .pop       (pop),
    .head_rd   (head_rd),
    .head_data (head_data),
    .count     (fifo_count),
    .full      (full),
    .empty     (empty),
    .ent_vld   (ent_vld),
    .ent_rd    (ent_rd)
  );

  always_comb begin
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    reg_write_d  = 1'b0;
    if (alu_wr) begin
      write_reg_d  = alu_rd;
      write_data_d = alu_data;
      reg_write_d  = 1'b1;
    end else if (pop) begin
      write_reg_d  = head_rd;
      write_data_d = head_data;
      reg_write_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      write_reg_q  <= '0;
      write_data_q <= '0;
      reg_write_q  <= 1'b0;
    end else begin
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      reg_write_q  <= reg_write_d;
    end
  end

  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign reg_write  = reg_write_q;

  // Pending = buffered in the FIFO or sitting in the output register this
  // cycle. Handshakes in flight this cycle are deliberately not included.
  logic hit1, hit2;
  always_comb begin
    hit1 = reg_write_q && (write_reg_q == query_rs1);
    hit2 = reg_write_q && (write_reg_q == query_rs2);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (ent_vld[i] && (ent_rd[i] == query_rs1)) hit1 = 1'b1;
      if (ent_vld[i] && (ent_rd[i] == query_rs2)) hit2 = 1'b1;
    end
  end

  assign busy_rs1 = (query_rs1 != RD_ZERO) && hit1;
  assign busy_rs2 = (query_rs2 != RD_ZERO) && hit2;

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready, mem_valid, mem_ready;
  logic [4:0]  alu_rd, mem_rd, write_reg, query_rs1, query_rs2;
  logic [31:0] alu_data, mem_data, write_data;
  logic        reg_write, busy_rs1, busy_rs2;
  logic [2:0]  fifo_count;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en   = 1'b0;

  wb_entry_t log_q[$];
  wb_entry_t exp_q[$];

  always #5 clk = ~clk;

  regfile_writeback dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
    .query_rs1(query_rs1), .query_rs2(query_rs2),
    .busy_rs1(busy_rs1), .busy_rs2(busy_rs2), .fifo_count(fifo_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Port contents are sampled before the flops update at each edge.
  always @(posedge clk) begin
    if (reg_write === 1'b1) log_q.push_back('{rd: write_reg, data: write_data});
    if (mon_en) chk("x0_write", {63'b0, reg_write && (write_reg == 5'd0)}, 64'd0);
  end

  task automatic cyc();
    @(negedge clk); #1;
  endtask

  task automatic clr();
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic ew(input logic [4:0] rd, input logic [31:0] d);
    exp_q.push_back('{rd: rd, data: d});
  endtask

  task automatic cmp_log(input string tag);
    chk({tag, "_n"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk($sformatf("%s_%0d", tag, i), log_q[i], exp_q[i]);
    clr();
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] d);
    alu_valid = 1'b1; alu_rd = rd; alu_data = d;
  endtask

  task automatic mem(input logic [4:0] rd, input logic [31:0] d);
    mem_valid = 1'b1; mem_rd = rd; mem_data = d;
  endtask

  initial begin
    reset = 1'b1; alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hDEAD_0003;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    query_rs1 = 5'd3; query_rs2 = 5'd0;

    // reset held 2 cycles with a live ALU request
    repeat (2) cyc();
    chk("rst_we",    reg_write, 0);
    chk("rst_wreg",  write_reg, 0);
    chk("rst_wdata", write_data, 0);
    chk("rst_cnt",   fifo_count, 0);
    chk("rst_ardy",  alu_ready, 1);
    chk("rst_mrdy",  mem_ready, 1);
    chk("rst_busy1", busy_rs1, 0);
    reset = 1'b0; alu_valid = 1'b0; mon_en = 1'b1;
    clr();
    repeat (3) cyc();
    cmp_log("rst_nowr");

    // single ALU write
    alu(5'd5, 32'h0000_0001);
    cyc();
    chk("alu_we",    reg_write, 1);
    chk("alu_wreg",  write_reg, 5);
    chk("alu_wdata", write_data, 1);
    alu_valid = 1'b0;
    cyc();
    chk("alu_we_off", reg_write, 0);
    cmp_log_prep: begin clr(); end

    // ALU priority over a buffered memory result
    query_rs1 = 5'd6;
    alu(5'd7, 32'h70); mem(5'd6, 32'hAAAA_BBBB);
    #1 chk("pri_busy_pre", busy_rs1, 0);
    cyc();
    chk("pri_busy1", busy_rs1, 1);
    chk("pri_wreg0", write_reg, 7);
    mem_valid = 1'b0; alu_data = 32'h71;
    cyc();
    chk("pri_busy2", busy_rs1, 1);
    alu_data = 32'h72;
    cyc();
    chk("pri_busy3", busy_rs1, 1);
    chk("pri_cnt",   fifo_count, 1);
    alu_valid = 1'b0;
    cyc();
    chk("pri_we6",   reg_write, 1);
    chk("pri_wreg6", write_reg, 6);
    chk("pri_data6", write_data, 32'hAAAA_BBBB);
    chk("pri_busy4", busy_rs1, 1);
    cyc();
    chk("pri_busy_off", busy_rs1, 0);
    chk("pri_we_off",   reg_write, 0);
    cyc();
    ew(7, 32'h70); ew(7, 32'h71); ew(7, 32'h72); ew(6, 32'hAAAA_BBBB);
    cmp_log("pri_log");

    // x0 filtering on both channels
    alu(5'd2, 32'h22); mem(5'd1, 32'h1234_5678);
    cyc();
    mem_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
    #1;
    chk("x0_ardy", alu_ready, 1);
    chk("x0_cnt1", fifo_count, 1);
    cyc();
    chk("x0_we",    reg_write, 1);
    chk("x0_wreg",  write_reg, 1);
    chk("x0_wdata", write_data, 32'h1234_5678);
    chk("x0_cnt0",  fifo_count, 0);
    alu_valid = 1'b0; mem(5'd0, 32'h55);
    #1 chk("x0_mrdy", mem_ready, 1);
    cyc();
    mem_valid = 1'b0;
    chk("x0_mem_cnt", fifo_count, 0);
    chk("x0_mem_we",  reg_write, 0);
    cyc();
    ew(2, 32'h22); ew(1, 32'h1234_5678);
    cmp_log("x0_log");

    // fill to full under a continuous ALU stream, then drain
    for (int i = 0; i < 4; i++) begin
      alu(5'd20, 32'(i)); mem(5'(8 + i), 32'((8 + i) << 8));
      cyc();
    end
    mem_valid = 1'b0; alu_data = 32'h4;
    #1;
    chk("full_cnt",  fifo_count, 4);
    chk("full_ardy", alu_ready, 0);
    chk("full_mrdy", mem_ready, 0);
    cyc();
    chk("full_we",   reg_write, 1);
    chk("full_wreg", write_reg, 8);
    chk("full_cnt3", fifo_count, 3);
    chk("full_ardy_back", alu_ready, 1);
    alu_valid = 1'b0;
    repeat (4) cyc();
    chk("full_cnt_end", fifo_count, 0);
    for (int i = 0; i < 4; i++) ew(20, 32'(i));
    for (int i = 8; i < 12; i++) ew(5'(i), 32'(i << 8));
    cmp_log("full_log");

    // reset with three buffered entries
    query_rs1 = 5'd12; query_rs2 = 5'd14;
    for (int i = 0; i < 3; i++) begin
      alu(5'd21, 32'(i)); mem(5'(12 + i), 32'(i + 'h100));
      cyc();
    end
    chk("mid_cnt3",  fifo_count, 3);
    chk("mid_busy1", busy_rs1, 1);
    chk("mid_busy2", busy_rs2, 1);
    alu_valid = 1'b0; mem_valid = 1'b0; reset = 1'b1;
    cyc();
    chk("mid_cnt0",   fifo_count, 0);
    chk("mid_busy1z", busy_rs1, 0);
    chk("mid_busy2z", busy_rs2, 0);
    chk("mid_we",     reg_write, 0);
    reset = 1'b0;
    repeat (5) cyc();
    for (int i = 0; i < 3; i++) ew(21, 32'(i));
    cmp_log("mid_log");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
